trig_in_conditioner: RTL and testbench
======================================

// Module: trig_in_conditioner
// PURPOSE
//  Multi-channel successor to the single registered target-trigger input path. Conditions pCHANNELS async
//  trigger inputs (target trig, userio pins), per channel: synchronise, glitch-filter, edge/level select.
//  Combines enabled channels (OR/AND), arms a pulse/holdoff FSM and drives one conditioned trigger
//  toward trace_top (m3_trig). Lives in fe_clk domain next to trace_top.
// PARAMETERS
//  pCHANNELS     4   number of trigger input channels (1..8)
//  pSYNC_STAGES  2   synchroniser flops per channel (>=2)
//  pFILTER_WIDTH 4   width of glitch-filter length setting
//  pPULSE_WIDTH  8   width of pulse-length and holdoff settings
//  pCOUNT_WIDTH  16  width of fired-trigger counter
// PORTS
//  fe_clk          in  1                 sole clock
//  fpga_reset      in  1                 synchronous, active-high reset
//  I_trig_in       in  pCHANNELS         raw async trigger inputs
//  I_chan_en       in  pCHANNELS         per-channel enable; 0 = channel ignored
//  I_mode          in  2*pCHANNELS       per channel [2c+1:2c]: 00 rise, 01 fall, 10 both, 11 high level
//  I_combine_and   in  1                 0 = OR of enabled channels, 1 = AND
//  I_filter_len    in  pFILTER_WIDTH     stable cycles required before filtered level changes; 0 = bypass
//  I_pulse_len     in  pPULSE_WIDTH      O_trig_out high for I_pulse_len+1 cycles
//  I_holdoff       in  pPULSE_WIDTH      dead cycles after pulse; 0 = none
//  I_arm           in  1                 level; high = armed
//  I_oneshot       in  1                 1 = disarm (IDLE) after one trigger until I_arm re-rises
//  I_clear_count   in  1                 clears O_trig_count
//  O_trig_out      out 1                 conditioned trigger (registered)
//  O_chan_level    out pCHANNELS         filtered per-channel levels
//  O_trig_count    out pCOUNT_WIDTH      triggers fired, saturating
//  O_state         out 2                 FSM state (00 IDLE, 01 ARMED, 10 PULSE, 11 HOLDOFF)
// BEHAVIOUR
//  Reset: all outputs 0, all sync/filter flops 0, filter counters 0, FSM IDLE.
//  Filter: filtered level takes the synced value once it differs for I_filter_len consecutive cycles;
//   counter restarts on any return to filtered value. Bypass (0): filtered = synced, one register stage.
//  Event per channel (from filtered and filtered-delayed): rise/fall/both edge pulse, or level = high.
//  Combine: OR = any enabled channel event; AND = every enabled channel event/level true in same cycle.
//   No channel enabled -> never fires (both modes).
//  Latency: raw edge to O_trig_out = pSYNC_STAGES + I_filter_len + 2 fe_clk cycles.
//  FSM: IDLE->ARMED on I_arm rising edge. ARMED->PULSE on combined event; O_trig_out high next cycle,
//   I_pulse_len and I_holdoff latched at fire. PULSE->HOLDOFF (or ARMED/IDLE if I_holdoff=0) after
//   I_pulse_len+1 cycles. HOLDOFF->ARMED (or IDLE if I_oneshot) after I_holdoff cycles.
//   Events in PULSE/HOLDOFF are dropped, not queued. Level mode refires every pulse+holdoff period.
//  I_arm low in any state: IDLE next cycle, O_trig_out low same edge (truncates pulse).
//  Config changes while ARMED take effect next cycle; during PULSE/HOLDOFF only latched values used.
//  Counter: +1 per fire (ARMED->PULSE); saturates at all-ones; I_clear_count wins but same-cycle
//   fire gives 1. fpga_reset mid-pulse: O_trig_out 0 next edge, counter 0.
// STRUCTURE
//  Mode codes and FSM state encodings as `defines in defines_trace.v (TRIG_MODE_*, TRIG_ST_*).
//  Sub-module trig_chan_filter (sync chain, filter counter, edge/level event), generated pCHANNELS
//  times; top holds combine logic, FSM, pulse/holdoff counter, trigger counter.
// TESTING
//  1 ch0 rise, filter 0, pulse 3, arm; I_trig_in[0] 0->1 -> O_trig_out high 4 cycles at edge+4, count=1.
//  2 filter 5; 3-cycle glitch on ch1 -> no trigger, O_chan_level[1] stays 0; 6-cycle high -> trigger.
//  3 AND, ch0 level + ch2 rise; ch2 rises with ch0 low -> none; with ch0 high -> one pulse.
//  4 ch0 level, pulse 1, holdoff 4, held high -> O_trig_out period 7 cycles; oneshot=1 -> exactly one.
//  5 I_arm dropped mid-pulse -> O_trig_out 0 next edge, O_state=00; no refire until I_arm re-rises.
//  6 pCOUNT_WIDTH=4: 17 fires -> count stays 15; clear coincident with fire -> count=1.

Source files
------------

// File: rtl/trig_in_conditioner_pkg.sv
// Shared mode/state encodings and the per-channel event decode for the
// multi-channel trigger input conditioner.
package trig_in_conditioner_pkg;

   typedef enum logic [1:0] {
      TRIG_MODE_RISE  = 2'b00,
      TRIG_MODE_FALL  = 2'b01,
      TRIG_MODE_BOTH  = 2'b10,
      TRIG_MODE_LEVEL = 2'b11
   } trig_mode_e;

   typedef enum logic [1:0] {
      TRIG_ST_IDLE    = 2'b00,
      TRIG_ST_ARMED   = 2'b01,
      TRIG_ST_PULSE   = 2'b10,
      TRIG_ST_HOLDOFF = 2'b11
   } trig_state_e;

   // Event from the filtered level and its one-cycle-delayed copy.
   function automatic logic trig_chan_event(input trig_mode_e mode,
                                            input logic       level,
                                            input logic       level_d);
      logic ev;
      case (mode)
         TRIG_MODE_RISE:  ev = level & ~level_d;
         TRIG_MODE_FALL:  ev = ~level & level_d;
         TRIG_MODE_BOTH:  ev = level ^ level_d;
         default:         ev = level;
      endcase
      return ev;
   endfunction

endpackage

// File: rtl/trig_in_conditioner_chan_filter.sv
// One trigger channel: synchroniser chain, glitch filter and edge/level
// event decode, all in the fe_clk domain.
module trig_in_conditioner_chan_filter
   import trig_in_conditioner_pkg::*;
#(
   parameter int pSYNC_STAGES  = 2,
   parameter int pFILTER_WIDTH = 4
) (
   input  logic                     fe_clk,
   input  logic                     fpga_reset,
   input  logic                     trig_in,
   input  logic [pFILTER_WIDTH-1:0] filter_len,
   input  trig_mode_e               mode,
   output logic                     level,
   output logic                     event_out
);

   localparam logic [pFILTER_WIDTH-1:0] FILT_ONE = {{(pFILTER_WIDTH-1){1'b0}}, 1'b1};

   logic [pSYNC_STAGES-1:0]  sync_reg;
   logic                     synced;
   logic                     filt_reg;
   logic                     filt_d_reg;
   logic [pFILTER_WIDTH-1:0] stable_cnt_reg;

   assign synced = sync_reg[pSYNC_STAGES-1];

   always_ff @(posedge fe_clk) begin
      if (fpga_reset) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[pSYNC_STAGES-2:0], trig_in};
      end
   end

   // The counter holds how many earlier cycles the synced value has already
   // disagreed; a zero length therefore degenerates to a plain register stage.
   always_ff @(posedge fe_clk) begin
      if (fpga_reset) begin
         filt_reg       <= 1'b0;
         filt_d_reg     <= 1'b0;
         stable_cnt_reg <= '0;
      end else begin
         filt_d_reg <= filt_reg;
         if (synced != filt_reg) begin
            if (stable_cnt_reg >= filter_len) begin
               filt_reg       <= synced;
               stable_cnt_reg <= '0;
            end else begin
               stable_cnt_reg <= stable_cnt_reg + FILT_ONE;
            end
         end else begin
            stable_cnt_reg <= '0;
         end
      end
   end

   assign level     = filt_reg;
   assign event_out = trig_chan_event(mode, filt_reg, filt_d_reg);

endmodule

// File: rtl/trig_in_conditioner.sv
// Multi-channel trigger conditioner: per-channel filtering, OR/AND combine,
// arm/pulse/holdoff FSM and a saturating fired-trigger counter.
module trig_in_conditioner
   import trig_in_conditioner_pkg::*;
#(
   parameter int pCHANNELS     = 4,
   parameter int pSYNC_STAGES  = 2,
   parameter int pFILTER_WIDTH = 4,
   parameter int pPULSE_WIDTH  = 8,
   parameter int pCOUNT_WIDTH  = 16
) (
   input  logic                     fe_clk,
   input  logic                     fpga_reset,
   input  logic [pCHANNELS-1:0]     I_trig_in,
   input  logic [pCHANNELS-1:0]     I_chan_en,
   input  logic [2*pCHANNELS-1:0]   I_mode,
   input  logic                     I_combine_and,
   input  logic [pFILTER_WIDTH-1:0] I_filter_len,
   input  logic [pPULSE_WIDTH-1:0]  I_pulse_len,
   input  logic [pPULSE_WIDTH-1:0]  I_holdoff,
   input  logic                     I_arm,
   input  logic                     I_oneshot,
   input  logic                     I_clear_count,
   output logic                     O_trig_out,
   output logic [pCHANNELS-1:0]     O_chan_level,
   output logic [pCOUNT_WIDTH-1:0]  O_trig_count,
   output logic [1:0]               O_state
);

   localparam logic [pPULSE_WIDTH-1:0] PULSE_ONE = {{(pPULSE_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [pCOUNT_WIDTH-1:0] COUNT_ONE = {{(pCOUNT_WIDTH-1){1'b0}}, 1'b1};

   logic [pCHANNELS-1:0] event_vec;
   logic [pCHANNELS-1:0] level_vec;

   for (genvar gi = 0; gi < pCHANNELS; gi++) begin : g_chan
      trig_in_conditioner_chan_filter #(
         .pSYNC_STAGES  (pSYNC_STAGES),
         .pFILTER_WIDTH (pFILTER_WIDTH)
      ) u_chan (
         .fe_clk     (fe_clk),
         .fpga_reset (fpga_reset),
         .trig_in    (I_trig_in[gi]),
         .filter_len (I_filter_len),
         .mode       (trig_mode_e'(I_mode[2*gi +: 2])),
         .level      (level_vec[gi]),
         .event_out  (event_vec[gi])
      );
   end

   assign O_chan_level = level_vec;

   // With no channel enabled the AND reduction would be vacuously true, so
   // it is gated by "any enabled" to keep both modes silent.
   logic any_event;
   logic all_event;
   logic comb_event;
   logic fire;

   assign any_event  = |(event_vec & I_chan_en);
   assign all_event  = (|I_chan_en) & (&(event_vec | ~I_chan_en));
   assign comb_event = I_combine_and ? all_event : any_event;

   trig_state_e             state_reg;
   logic                    trig_out_reg;
   logic                    arm_d_reg;
   logic [pPULSE_WIDTH-1:0] phase_cnt_reg;
   logic [pPULSE_WIDTH-1:0] pulse_len_reg;
   logic [pPULSE_WIDTH-1:0] holdoff_reg;
   logic                    oneshot_reg;

   assign fire = (state_reg == TRIG_ST_ARMED) & I_arm & comb_event;

   // Timing settings are captured at fire so PULSE/HOLDOFF ignore live edits.
   always_ff @(posedge fe_clk) begin
      if (fpga_reset) begin
         state_reg     <= TRIG_ST_IDLE;
         trig_out_reg  <= 1'b0;
         arm_d_reg     <= 1'b0;
         phase_cnt_reg <= '0;
         pulse_len_reg <= '0;
         holdoff_reg   <= '0;
         oneshot_reg   <= 1'b0;
      end else begin
         arm_d_reg <= I_arm;
         if (!I_arm) begin
            state_reg    <= TRIG_ST_IDLE;
            trig_out_reg <= 1'b0;
         end else begin
            case (state_reg)
               TRIG_ST_IDLE: begin
                  if (!arm_d_reg) begin
                     state_reg <= TRIG_ST_ARMED;
                  end
               end
               TRIG_ST_ARMED: begin
                  if (fire) begin
                     state_reg     <= TRIG_ST_PULSE;
                     trig_out_reg  <= 1'b1;
                     phase_cnt_reg <= '0;
                     pulse_len_reg <= I_pulse_len;
                     holdoff_reg   <= I_holdoff;
                     oneshot_reg   <= I_oneshot;
                  end
               end
               TRIG_ST_PULSE: begin
                  if (phase_cnt_reg == pulse_len_reg) begin
                     trig_out_reg  <= 1'b0;
                     phase_cnt_reg <= '0;
                     if (holdoff_reg != '0) begin
                        state_reg <= TRIG_ST_HOLDOFF;
                     end else if (oneshot_reg) begin
                        state_reg <= TRIG_ST_IDLE;
                     end else begin
                        state_reg <= TRIG_ST_ARMED;
                     end
                  end else begin
                     phase_cnt_reg <= phase_cnt_reg + PULSE_ONE;
                  end
               end
               TRIG_ST_HOLDOFF: begin
                  if ((phase_cnt_reg + PULSE_ONE) == holdoff_reg) begin
                     phase_cnt_reg <= '0;
                     state_reg     <= oneshot_reg ? TRIG_ST_IDLE : TRIG_ST_ARMED;
                  end else begin
                     phase_cnt_reg <= phase_cnt_reg + PULSE_ONE;
                  end
               end
               default: begin
                  state_reg <= TRIG_ST_IDLE;
               end
            endcase
         end
      end
   end

   // Clear has priority, but a fire in the same cycle is still counted.
   logic [pCOUNT_WIDTH-1:0] trig_count_reg;

   always_ff @(posedge fe_clk) begin
      if (fpga_reset) begin
         trig_count_reg <= '0;
      end else if (I_clear_count) begin
         trig_count_reg <= fire ? COUNT_ONE : '0;
      end else if (fire && !(&trig_count_reg)) begin
         trig_count_reg <= trig_count_reg + COUNT_ONE;
      end
   end

   assign O_trig_out   = trig_out_reg;
   assign O_trig_count = trig_count_reg;
   assign O_state      = state_reg;

endmodule

// File: tb/tb_trig_in_conditioner.sv
// Directed and randomized checks of trig_in_conditioner against a
// time-based reference model of the trigger rules.
module tb_trig_in_conditioner;

   localparam int NCH = 4;
   localparam int NS  = 2;
   localparam int FW  = 4;
   localparam int PW  = 8;
   localparam int CW  = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic            fe_clk = 1'b0;
   logic            fpga_reset;
   logic [NCH-1:0]  I_trig_in;
   logic [NCH-1:0]  I_chan_en;
   logic [2*NCH-1:0] I_mode;
   logic            I_combine_and;
   logic [FW-1:0]   I_filter_len;
   logic [PW-1:0]   I_pulse_len;
   logic [PW-1:0]   I_holdoff;
   logic            I_arm;
   logic            I_oneshot;
   logic            I_clear_count;
   logic            O_trig_out;
   logic [NCH-1:0]  O_chan_level;
   logic [CW-1:0]   O_trig_count;
   logic [1:0]      O_state;

   always #5 fe_clk = ~fe_clk;

   trig_in_conditioner #(
      .pCHANNELS     (NCH),
      .pSYNC_STAGES  (NS),
      .pFILTER_WIDTH (FW),
      .pPULSE_WIDTH  (PW),
      .pCOUNT_WIDTH  (CW)
   ) dut (
      .fe_clk        (fe_clk),
      .fpga_reset    (fpga_reset),
      .I_trig_in     (I_trig_in),
      .I_chan_en     (I_chan_en),
      .I_mode        (I_mode),
      .I_combine_and (I_combine_and),
      .I_filter_len  (I_filter_len),
      .I_pulse_len   (I_pulse_len),
      .I_holdoff     (I_holdoff),
      .I_arm         (I_arm),
      .I_oneshot     (I_oneshot),
      .I_clear_count (I_clear_count),
      .O_trig_out    (O_trig_out),
      .O_chan_level  (O_chan_level),
      .O_trig_count  (O_trig_count),
      .O_state       (O_state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: raw-input history, run-length filter, and absolute
   // edge times for pulse end / holdoff end instead of a state register.
   logic [NCH-1:0] hist [0:255];
   int             k = 0;
   logic [NCH-1:0] m_filt, m_filt_d;
   int             m_run [NCH];
   bit             m_active, m_oneshot_l, m_arm_prev;
   int             m_p_end, m_h_end, m_cnt;
   logic           m_trig;
   logic [1:0]     m_state;

   function automatic logic chan_ev(input logic [1:0] mode, input logic f, input logic fd);
      case (mode)
         2'd0:    return f & ~fd;
         2'd1:    return ~f & fd;
         2'd2:    return f ^ fd;
         default: return f;
      endcase
   endfunction

   task automatic model_edge();
      logic [NCH-1:0] ev, new_f, syn;
      logic comb, fire;
      if (fpga_reset) begin
         for (int j = 0; j < NS; j++) hist[(k - j) & 255] = '0;
         m_filt = '0; m_filt_d = '0;
         for (int c = 0; c < NCH; c++) m_run[c] = 0;
         m_active = 0; m_arm_prev = 0; m_oneshot_l = 0;
         m_p_end = -1; m_h_end = -1; m_cnt = 0;
      end else begin
         for (int c = 0; c < NCH; c++) ev[c] = chan_ev(I_mode[2*c +: 2], m_filt[c], m_filt_d[c]);
         if (I_combine_and) comb = (I_chan_en != 0) && ((ev | ~I_chan_en) == {NCH{1'b1}});
         else               comb = ((ev & I_chan_en) != 0);
         fire = 0;
         if (!I_arm) begin
            m_active = 0; m_p_end = -1; m_h_end = -1;
         end else if (!m_active) begin
            if (!m_arm_prev) m_active = 1;
         end else if (k == m_h_end && m_oneshot_l) begin
            m_active = 0;
         end else if (k > m_h_end && comb) begin
            fire = 1;
            m_p_end = k + int'(I_pulse_len) + 1;
            m_h_end = m_p_end + int'(I_holdoff);
            m_oneshot_l = I_oneshot;
         end
         if (I_clear_count) m_cnt = fire ? 1 : 0;
         else if (fire && m_cnt < CMAX) m_cnt++;
         m_arm_prev = I_arm;
         syn = hist[(k - NS) & 255];
         new_f = m_filt;
         for (int c = 0; c < NCH; c++) begin
            if (syn[c] != m_filt[c]) begin
               m_run[c]++;
               if (m_run[c] > int'(I_filter_len)) begin
                  new_f[c] = syn[c];
                  m_run[c] = 0;
               end
            end else begin
               m_run[c] = 0;
            end
         end
         m_filt_d = m_filt;
         m_filt   = new_f;
         hist[k & 255] = I_trig_in;
      end
      m_trig = m_active && (k < m_p_end);
      if (!m_active)        m_state = 2'd0;
      else if (k < m_p_end) m_state = 2'd2;
      else if (k < m_h_end) m_state = 2'd3;
      else                  m_state = 2'd1;
      k++;
   endtask

   task automatic cycle(input int n);
      repeat (n) begin
         @(posedge fe_clk);
         model_edge();
         #1;
         check("trig_out",   32'(O_trig_out),   32'(m_trig));
         check("chan_level", 32'(O_chan_level), 32'(m_filt));
         check("trig_count", 32'(O_trig_count), 32'(m_cnt));
         check("state",      32'(O_state),      32'(m_state));
      end
   endtask

   task automatic run_count(input int n, output int rises);
      logic prev;
      prev  = O_trig_out;
      rises = 0;
      repeat (n) begin
         cycle(1);
         if (O_trig_out && !prev) rises++;
         prev = O_trig_out;
      end
   endtask

   task automatic wait_high(input int n, output bit seen);
      seen = 0;
      for (int i = 0; i < n && !seen; i++) begin
         cycle(1);
         if (O_trig_out) seen = 1;
      end
   endtask

   initial begin
      int  first, highs, r, t_a, t_b;
      bit  seen, lvl;
      logic prev;
      for (int i = 0; i < 256; i++) hist[i] = '0;
      fpga_reset = 1; I_trig_in = '0; I_chan_en = '0; I_mode = '0; I_combine_and = 0;
      I_filter_len = '0; I_pulse_len = '0; I_holdoff = '0; I_arm = 0; I_oneshot = 0;
      I_clear_count = 0;
      cycle(4);
      $display("reset: state=%0d count=%0d trig=%0d", O_state, O_trig_count, O_trig_out);

      // Test 1: single rise, bypass filter, 4-cycle pulse.
      fpga_reset = 0; I_chan_en = 4'b0001; I_pulse_len = 8'd3; I_arm = 1;
      cycle(3);
      I_trig_in[0] = 1; first = -1; highs = 0;
      for (int i = 1; i <= 12; i++) begin
         cycle(1);
         if (O_trig_out) begin
            highs++;
            if (first < 0) first = i;
         end
      end
      check("t1_latency", 32'(first), 32'd4);
      check("t1_width",   32'(highs), 32'd4);
      check("t1_count",   32'(O_trig_count), 32'd1);
      $display("t1: latency=%0d width=%0d count=%0d", first, highs, O_trig_count);

      // Test 2: glitch filter on ch1.
      I_chan_en = 4'b0010; I_filter_len = 4'd5;
      cycle(2);
      lvl = 0; seen = 0;
      for (int i = 0; i < 15; i++) begin
         I_trig_in[1] = (i < 3);
         cycle(1);
         lvl  |= O_chan_level[1];
         seen |= O_trig_out;
      end
      check("t2_glitch_level", 32'(lvl), 32'd0);
      check("t2_glitch_trig",  32'(seen), 32'd0);
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         I_trig_in[1] = (i < 6);
         cycle(1);
         seen |= O_trig_out;
      end
      check("t2_six_cycle_trig", 32'(seen), 32'd1);
      $display("t2: glitch_level=%0d six_cycle_fired=%0d", lvl, seen);

      // Test 3: AND of ch0 level and ch2 rise.
      I_combine_and = 1; I_chan_en = 4'b0101; I_mode = 8'h03; I_filter_len = '0;
      I_trig_in = '0;
      cycle(6);
      I_trig_in[2] = 1; run_count(10, r);
      check("t3_and_ch0_low", 32'(r), 32'd0);
      I_trig_in[2] = 0; cycle(4);
      I_trig_in[0] = 1; run_count(8, r);
      check("t3_and_level_only", 32'(r), 32'd0);
      I_trig_in[2] = 1; run_count(12, r);
      check("t3_and_both", 32'(r), 32'd1);
      $display("t3: and_both_pulses=%0d", r);

      // Test 4: level refire period and oneshot.
      I_combine_and = 0; I_chan_en = 4'b0001; I_pulse_len = 8'd1; I_holdoff = 8'd4;
      t_a = -1; t_b = -1; prev = O_trig_out;
      for (int i = 0; i < 30; i++) begin
         cycle(1);
         if (O_trig_out && !prev) begin
            if (t_a < 0) t_a = i;
            else if (t_b < 0) t_b = i;
         end
         prev = O_trig_out;
      end
      check("t4_period", 32'(t_b - t_a), 32'd7);
      I_arm = 0; cycle(1);
      I_oneshot = 1; I_arm = 1;
      run_count(30, r);
      check("t4_oneshot", 32'(r), 32'd1);
      check("t4_oneshot_idle", 32'(O_state), 32'd0);
      $display("t4: period=%0d oneshot_pulses=%0d", t_b - t_a, r);
      I_oneshot = 0;

      // Test 5: arm dropped mid-pulse.
      I_pulse_len = 8'd5; I_holdoff = '0;
      I_arm = 0; cycle(1); I_arm = 1;
      wait_high(20, seen);
      check("t5_fired", 32'(seen), 32'd1);
      cycle(1);
      I_arm = 0; cycle(1);
      check("t5_trig_dropped", 32'(O_trig_out), 32'd0);
      check("t5_idle", 32'(O_state), 32'd0);
      run_count(10, r);
      check("t5_no_refire", 32'(r), 32'd0);
      I_arm = 1; run_count(10, r);
      check("t5_rearm_fires", 32'(r > 0), 32'd1);
      $display("t5: rearm_pulses=%0d", r);

      // Reset in the middle of a pulse.
      wait_high(20, seen);
      check("rst_fired", 32'(seen), 32'd1);
      fpga_reset = 1; cycle(1);
      check("rst_trig", 32'(O_trig_out), 32'd0);
      check("rst_count", 32'(O_trig_count), 32'd0);
      fpga_reset = 0; cycle(3);

      // Test 6: saturation and clear coincident with fire.
      I_pulse_len = '0; I_holdoff = '0;
      I_clear_count = 1; cycle(1); I_clear_count = 0;
      cycle(60);
      check("t6_saturate", 32'(O_trig_count), 32'(CMAX));
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (O_state == 2'd1) seen = 1;
         else cycle(1);
      end
      check("t6_found_armed", 32'(seen), 32'd1);
      I_clear_count = 1; cycle(1); I_clear_count = 0;
      check("t6_clear_fire", 32'(O_trig_count), 32'd1);
      check("t6_clear_state", 32'(O_state), 32'd2);
      $display("t6: count_after_clear_fire=%0d", O_trig_count);

      // Randomized run against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 63) == 0) begin
            I_chan_en     = NCH'($urandom);
            I_mode        = (2*NCH)'($urandom);
            I_combine_and = 1'($urandom);
            I_filter_len  = FW'($urandom_range(0, 3));
            I_pulse_len   = PW'($urandom_range(0, 4));
            I_holdoff     = PW'($urandom_range(0, 4));
            I_oneshot     = ($urandom_range(0, 3) == 0);
         end
         if ($urandom_range(0, 49) == 0) I_arm = ~I_arm;
         I_clear_count = ($urandom_range(0, 39) == 0);
         fpga_reset    = ($urandom_range(0, 499) == 0);
         I_trig_in     = I_trig_in ^ NCH'($urandom & $urandom);
         cycle(1);
      end
      fpga_reset = 0; I_clear_count = 0;
      $display("random: %0d cycles done", 3000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
